// File: rtl/mf_pll_reset_seq.sv
// mf_pll_reset_seq: PLL lock supervisor and staggered per-domain reset sequencer.
//
// Runs on the PLL reference clock, because PLL outputs cannot be trusted before lock.
// Build option: define MF_PLL_RELOCK_COUNT_EN to implement the saturating restart
// counter; otherwise relock_count is tied to zero.
//
// Ports:
//   refclk       - reference clock, same clock that feeds the PLL
//   rst_n        - asynchronous active-low reset of this block
//   pll_locked   - PLL lock indication, asynchronous to refclk
//   sw_reset     - synchronous request to restart the whole sequence
//   pll_rst      - active-high PLL reset
//   domain_rst_n - active-low domain resets, released one at a time in index order
//   ready        - high only while every domain is out of reset and lock is held
//   relock_count - saturating count of restart events
module mf_pll_reset_seq #(
  parameter int NUM_DOMAINS         = 4,
  parameter int CNT_W               = 24,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int STAGGER_CYCLES      = 8,
  parameter int LOSS_FILTER_CYCLES  = 4
) (
  input  logic                   refclk,
  input  logic                   rst_n,
  input  logic                   pll_locked,
  input  logic                   sw_reset,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             relock_count
);
  localparam int IDX_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [1:0] S_PLL_RST   = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_RELEASE   = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic [1:0]             r_sync;
  logic [1:0]             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       r_stable;
  logic [CNT_W-1:0]       r_loss;
  logic [IDX_W-1:0]       r_idx;
  logic                   r_pll_rst;
  logic                   r_ready;
  logic [NUM_DOMAINS-1:0] r_dom;

  logic w_lk_s, w_release, w_timeout, w_drop, w_loss, w_abort, w_step, w_last;

  assign w_lk_s    = r_sync[1];
  // A release on the final timeout cycle takes precedence over the timeout.
  assign w_release = r_state == S_WAIT_LOCK && w_lk_s && r_stable == CNT_W'(LOCK_STABLE_CYCLES - 1);
  assign w_timeout = r_state == S_WAIT_LOCK && !w_release && r_cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  assign w_drop    = r_state == S_RELEASE && !w_lk_s;
  assign w_loss    = r_state == S_RUN && !w_lk_s && r_loss == CNT_W'(LOSS_FILTER_CYCLES - 1);
  assign w_abort   = w_timeout || w_drop || w_loss;
  assign w_step    = r_state == S_RELEASE && r_cnt == CNT_W'(STAGGER_CYCLES - 1);
  assign w_last    = r_idx == IDX_W'(NUM_DOMAINS - 1);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync    <= '0;
      r_state   <= S_PLL_RST;
      r_cnt     <= '0;
      r_stable  <= '0;
      r_loss    <= '0;
      r_idx     <= '0;
      r_pll_rst <= 1'b1;
      r_dom     <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
      if (sw_reset || w_abort) begin
        // Every restart path lands in the same place as a hard reset.
        r_state   <= S_PLL_RST;
        r_cnt     <= '0;
        r_stable  <= '0;
        r_loss    <= '0;
        r_idx     <= '0;
        r_pll_rst <= 1'b1;
        r_dom     <= '0;
        r_ready   <= 1'b0;
      end else begin
        case (r_state)
          S_PLL_RST: begin
            if (r_cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
              r_state   <= S_WAIT_LOCK;
              r_cnt     <= '0;
              r_pll_rst <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            r_stable <= w_lk_s ? r_stable + 1'b1 : '0;
            if (w_release) begin
              r_state  <= S_RELEASE;
              r_cnt    <= '0;
              r_stable <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            if (w_step) begin
              r_dom[r_idx] <= 1'b1;
              r_cnt        <= '0;
              r_idx        <= r_idx + 1'b1;
              if (w_last) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_loss <= w_lk_s ? '0 : r_loss + 1'b1;
        endcase
      end
    end
  end

  assign pll_rst      = r_pll_rst;
  assign domain_rst_n = r_dom;
  assign ready        = r_ready;

`ifdef MF_PLL_RELOCK_COUNT_EN
  logic [7:0] r_relock;
  logic       w_restart;

  // A software request while already in PLL_RST is not a new restart.
  assign w_restart = (sw_reset && r_state != S_PLL_RST) || w_abort;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) r_relock <= '0;
    else if (w_restart && r_relock != 8'hFF) r_relock <= r_relock + 1'b1;
  end

  assign relock_count = r_relock;
`else
  assign relock_count = 8'd0;
`endif
endmodule

// File: tb/tb_mf_pll_reset_seq.sv
// tb_mf_pll_reset_seq: directed scoreboard bench for mf_pll_reset_seq.
module tb_mf_pll_reset_seq;
`ifdef MF_PLL_RELOCK_COUNT_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif
  localparam int BO [11] = '{1, 3, 4, 12, 13, 14, 15, 16, 18, 19, 20};
  localparam logic [3:0] BD [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h3, 4'h7, 4'h7, 4'hF};

  typedef struct {
    int          at;
    logic [13:0] val;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b1;
  logic       sw_reset = 1'b0;
  logic       pll_rst;
  logic [3:0] domain_rst_n;
  logic       ready;
  logic [7:0] relock_count;
  logic [13:0] obs;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int rc = 0;
  exp_t q[$];

  mf_pll_reset_seq #(
    .NUM_DOMAINS(4), .CNT_W(24), .PLL_RST_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64), .STAGGER_CYCLES(2), .LOSS_FILTER_CYCLES(3)
  ) dut (
    .refclk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_reset(sw_reset),
    .pll_rst(pll_rst), .domain_rst_n(domain_rst_n), .ready(ready), .relock_count(relock_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {pll_rst, domain_rst_n, ready, relock_count};

  function automatic logic [13:0] ev(logic p, logic [3:0] d, logic r);
    return {p, d, r, RC_EN ? 8'(rc) : 8'd0};
  endfunction

  task automatic push(int at, logic [13:0] val, string tag);
    exp_t e;
    e.at = at;
    e.val = val;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic cmp(string tag, logic [13:0] o, logic [13:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed {pll_rst,dom,ready,rc}=%h expected %h", tag, o, e);
    end
  endtask

  task automatic run_to(int c, bit tog = 1'b0);
    exp_t e;
    while (cyc < c) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        if (e.at < cyc) begin
          n_cmp++;
          n_err++;
          $error("FAIL %s: check at cycle %0d skipped (now %0d)", e.tag, e.at, cyc);
        end else begin
          cmp($sformatf("%s@%0d", e.tag, e.at), obs, e.val);
        end
      end
      if (tog && cyc % 5 == 0) pll_locked = ~pll_locked;
    end
  endtask

  task automatic exp_bringup(int b, int last);
    for (int i = 0; i < 11; i++)
      if (BO[i] <= last) push(b + BO[i], ev(BO[i] < 4, BD[i], BO[i] == 20), $sformatf("bringup+%0d", BO[i]));
  endtask

  function automatic int sat(int v);
    return v < 255 ? v + 1 : 255;
  endfunction

  initial begin
    int b, c, s;
    repeat (3) @(negedge clk);
    cmp("reset", obs, ev(1'b1, 4'h0, 1'b0));
    rst_n = 1'b1;
    b = cyc;
    exp_bringup(b, 20);
    run_to(b + 25);
    c = cyc;
    pll_locked = 1'b0;
    push(c + 4, ev(1'b0, 4'hF, 1'b1), "glitch2");
    push(c + 6, ev(1'b0, 4'hF, 1'b1), "glitch2");
    run_to(c + 2);
    pll_locked = 1'b1;
    run_to(c + 10);
    c = cyc;
    pll_locked = 1'b0;
    push(c + 4, ev(1'b0, 4'hF, 1'b1), "loss_pre");
    rc = sat(rc);
    push(c + 5, ev(1'b1, 4'h0, 1'b0), "loss_trip");
    run_to(c + 3);
    pll_locked = 1'b1;
    exp_bringup(c + 5, 20);
    run_to(c + 27);
    c = cyc;
    sw_reset = 1'b1;
    rc = sat(rc);
    push(c + 1, ev(1'b1, 4'h0, 1'b0), "sw_pulse");
    run_to(c + 1);
    sw_reset = 1'b0;
    b = c + 1;
    exp_bringup(b, 16);
    run_to(b + 16);
    pll_locked = 1'b0;
    push(b + 18, ev(1'b0, 4'h7, 1'b0), "rel_pre");
    rc = sat(rc);
    push(b + 19, ev(1'b1, 4'h0, 1'b0), "rel_drop");
    run_to(b + 19);
    pll_locked = 1'b1;
    exp_bringup(b + 19, 20);
    run_to(b + 41);
    c = cyc;
    sw_reset = 1'b1;
    rc = sat(rc);
    push(c + 1, ev(1'b1, 4'h0, 1'b0), "sw_hold");
    push(c + 5, ev(1'b1, 4'h0, 1'b0), "sw_hold");
    push(c + 10, ev(1'b1, 4'h0, 1'b0), "sw_hold");
    run_to(c + 10);
    sw_reset = 1'b0;
    exp_bringup(c + 10, 20);
    run_to(c + 32);
    #1 rst_n = 1'b0;
    rc = 0;
    #1 cmp("async_rst", obs, ev(1'b1, 4'h0, 1'b0));
    pll_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b = cyc;
    push(b + 4, ev(1'b0, 4'h0, 1'b0), "nolock");
    push(b + 67, ev(1'b0, 4'h0, 1'b0), "nolock_pre");
    rc = 1;
    push(b + 68, ev(1'b1, 4'h0, 1'b0), "timeout1");
    push(b + 72, ev(1'b0, 4'h0, 1'b0), "nolock");
    push(b + 135, ev(1'b0, 4'h0, 1'b0), "nolock_pre");
    rc = 2;
    push(b + 136, ev(1'b1, 4'h0, 1'b0), "timeout2");
    rc = 3;
    push(b + 204, ev(1'b1, 4'h0, 1'b0), "timeout3");
    run_to(b + 204);
    push(b + 271, ev(1'b0, 4'h0, 1'b0), "unstable_pre");
    rc = 4;
    push(b + 272, ev(1'b1, 4'h0, 1'b0), "unstable_timeout");
    run_to(b + 272, 1'b1);
    pll_locked = 1'b0;
    s = b + 272;
    for (int i = 0; i < 260; i++) begin
      run_to(s + 4);
      sw_reset = 1'b1;
      rc = sat(rc);
      push(s + 5, ev(1'b1, 4'h0, 1'b0), "saturate");
      run_to(s + 5);
      sw_reset = 1'b0;
      s = s + 5;
    end
    run_to(cyc + 3);
    if (q.size() != 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard: %0d expectations left unchecked, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
